// File: rtl/rename_tag_pool.sv
// Physical-register free list: speculative/committed read heads, multi-lane alloc and free.
// Define TAG_POOL_BYPASS_EN to let this cycle's freed tags satisfy this cycle's allocations.
module rename_tag_pool #(
    parameter int NUM_TAGS   = 64,
    parameter int NUM_ARCH   = 32,
    parameter int NUM_ISSUE  = 4,
    parameter int NUM_COMMIT = 4,
    parameter int TAG_W      = $clog2(NUM_TAGS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_ISSUE-1:0]        IN_allocReq,
    input  logic                        IN_allocFire,
    output logic [NUM_ISSUE*TAG_W-1:0]  OUT_allocTags,
    output logic [NUM_ISSUE-1:0]        OUT_allocValid,
    input  logic [NUM_COMMIT-1:0]       IN_freeValid,
    input  logic [NUM_COMMIT*TAG_W-1:0] IN_freeTags,
    input  logic [NUM_COMMIT-1:0]       IN_commitConsume,
    input  logic                        IN_flush,
    output logic [TAG_W:0]              OUT_freeCount
);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [TAG_W:0] ptr_t;

    logic [TAG_W-1:0] fl [NUM_TAGS];
    ptr_t specHead;
    ptr_t comHead;
    ptr_t tail;
    ptr_t specHeadNext;

    ptr_t allocPos [NUM_ISSUE];
    ptr_t allocTotal;
    ptr_t freePos [NUM_COMMIT];
    ptr_t freeTotal;
    ptr_t commitTotal;
    logic fireOk;

    assign OUT_freeCount = tail - specHead;

    always_comb begin
        allocTotal = '0;
        for (int i = 0; i < NUM_ISSUE; i++) begin
            allocPos[i] = allocTotal;
            allocTotal  = allocTotal + ptr_t'(IN_allocReq[i]);
        end
    end

    always_comb begin
        freeTotal   = '0;
        commitTotal = '0;
        for (int j = 0; j < NUM_COMMIT; j++) begin
            freePos[j]  = freeTotal;
            freeTotal   = freeTotal + ptr_t'(IN_freeValid[j]);
            commitTotal = commitTotal + ptr_t'(IN_commitConsume[j]);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_ISSUE; gi++) begin : gLane
            logic [TAG_W-1:0] rdIdx;
            logic [TAG_W-1:0] storedTag;

            assign rdIdx     = TAG_W'(specHead + allocPos[gi]);
            assign storedTag = fl[rdIdx];
`ifdef TAG_POOL_BYPASS_EN
            ptr_t             fwdIdx;
            logic [TAG_W-1:0] fwdTag;

            // Lanes beyond the stored pool pick the matching valid free lane by rank.
            assign fwdIdx = allocPos[gi] - OUT_freeCount;
            always_comb begin
                fwdTag = '0;
                for (int j = 0; j < NUM_COMMIT; j++) begin
                    if (IN_freeValid[j] && (freePos[j] == fwdIdx)) begin
                        fwdTag = IN_freeTags[j*TAG_W +: TAG_W];
                    end
                end
            end
            assign OUT_allocTags[gi*TAG_W +: TAG_W] =
                (allocPos[gi] < OUT_freeCount) ? storedTag : fwdTag;
            assign OUT_allocValid[gi] = IN_allocReq[gi] &&
                ({1'b0, allocPos[gi]} < ({1'b0, OUT_freeCount} + {1'b0, freeTotal}));
`else
            assign OUT_allocTags[gi*TAG_W +: TAG_W] = storedTag;
            assign OUT_allocValid[gi] = IN_allocReq[gi] && (allocPos[gi] < OUT_freeCount);
`endif
        end
    endgenerate

    // A fire only counts when every requesting lane got a usable tag.
    assign fireOk = &(OUT_allocValid | ~IN_allocReq);

    always_comb begin
        specHeadNext = specHead;
        if (IN_flush) begin
            specHeadNext = comHead + commitTotal;
        end else if (IN_allocFire && fireOk) begin
            specHeadNext = specHead + allocTotal;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            specHead <= '0;
            comHead  <= '0;
            tail     <= ptr_t'(NUM_TAGS - NUM_ARCH);
            for (int k = 0; k < NUM_TAGS; k++) begin
                fl[k] <= TAG_W'(NUM_ARCH + k);
            end
        end else begin
            specHead <= specHeadNext;
            comHead  <= comHead + commitTotal;
            tail     <= tail + freeTotal;
            for (int j = 0; j < NUM_COMMIT; j++) begin
                if (IN_freeValid[j]) begin
                    fl[TAG_W'(tail + freePos[j])] <= IN_freeTags[j*TAG_W +: TAG_W];
                end
            end
        end
    end

endmodule
